zda_frame_sequencer: RTL and testbench
======================================

// Module: zda_frame_sequencer
// PURPOSE
//  Sequences an external B-bit header comparer (restart/load/data in, resolve/reject out) over an RX byte stream.
//  Hunts for '$', feeds header bytes to the comparer and acts on its verdict.
//  On a match, forwards payload bytes tagged with a comma-field index, then checks the NMEA XOR checksum.
//  Sits between the UART RX byte strobe and the ZDA field decoders.
// PARAMETERS
//  B        8       bits per byte (rx and comparer data width)
//  L        6       header length in bytes including '$' (must equal comparer L)
//  TIMEOUT  100000  idle cycles allowed between bytes inside a frame (1 ms @ 100 MHz)
//  MAX_LEN  82      max bytes after header before forced abort
//  FW       4       field index width
// PORTS
//  clock          in   1   100 MHz clock
//  reset          in   1   synchronous, active-high reset
//  rx_valid       in   1   one-cycle strobe, rx_data valid; successive strobes >= 3 cycles apart
//  rx_data        in   B   received byte
//  cmp_restart    out  1   comparer restart (registered)
//  cmp_load       out  1   comparer load strobe (registered)
//  cmp_data       out  B   comparer data (registered)
//  cmp_resolve    in   1   comparer full-match pulse
//  cmp_reject     in   1   comparer mismatch pulse
//  frame_start    out  1   pulse: header matched
//  pay_valid      out  1   pulse: pay_data/pay_field valid
//  pay_data       out  B   payload byte (',' and '*' not forwarded)
//  pay_field      out  FW  field index of pay_data; 0 = first field after header comma
//  frame_done     out  1   pulse: checksum correct
//  frame_error    out  1   pulse: checksum bad / timeout / overlength / resync in payload
//  frame_skip     out  1   pulse: header rejected (other sentence type)
// BEHAVIOUR
//  - Reset: state=IDLE; cmp_restart=1; all other outputs 0; counters and XOR accumulator 0.
//  - All outputs registered; every event is visible 1 cycle after the rx_valid or cmp_* that causes it.
//  - States: IDLE, HEADER, PAYLOAD, CKSUM_HI, CKSUM_LO.
//  - IDLE:
//      cmp_restart=1; bytes other than '$' are ignored (CR/LF included).
//      On '$' at cycle t: at t+1 state=HEADER, cmp_restart=0, cmp_load=1, cmp_data='$', hdr_cnt=1.
//  - HEADER:
//      Each rx_valid gives a cmp_load pulse with that byte next cycle; hdr_cnt++; XOR accumulates every byte except '$'.
//      cmp_resolve/cmp_reject are 1-cycle pulses; sampled every cycle.
//      Resolve -> PAYLOAD, frame_start pulse, field=0.
//      Reject -> IDLE, frame_skip pulse.
//      hdr_cnt==L and no verdict within 2 cycles of the last load -> IDLE, frame_error.
//  - PAYLOAD:
//      Header's trailing ',' (byte L+1) is XORed but not forwarded; field stays 0.
//      Each later byte is XORed.
//      ',' -> field++, saturating at 2^FW-1; not forwarded.
//      '*' -> CKSUM_HI; not XORed.
//      Any other byte -> pay_valid pulse with pay_data=byte and pay_field=field.
//  - CKSUM_HI/LO: accept only '0'-'9','A'-'F'; a non-hex byte -> IDLE, frame_error.
//      After LO, compare {hi,lo} with XOR accumulator -> IDLE with frame_done (equal) or frame_error (unequal).
//  - '$' in any non-IDLE state = resync:
//      frame_error if in PAYLOAD/CKSUM_*; no pulse if in HEADER.
//      Then behaves exactly as '$' in IDLE: cmp_restart=1 for 1 cycle, then load '$' the following cycle.
//  - Idle timer:
//      Clears on each rx_valid; counts in non-IDLE states only.
//      Reaching TIMEOUT -> IDLE, frame_error (or nothing if in HEADER).
//      Byte counter after header exceeding MAX_LEN -> IDLE, frame_error.
//  - Simultaneity:
//      Timeout and rx_valid in the same cycle: rx_valid wins.
//      cmp_resolve and rx_valid in the same cycle: resolve handled first, then the byte is treated as payload.
//      cmp_resolve and cmp_reject both high: reject wins.
//  - Reset mid-frame: return to reset values next cycle; no pulses emitted.
//  - At most one of frame_start/frame_done/frame_error/frame_skip high per cycle.
// TESTING
//  1. "$GPZDA,1*55" with a matching comparer model
//     -> frame_start; pay_valid '1' with pay_field 0; frame_done; no frame_error.
//  2. "$GPZDA,12,34*hh" with hh = correct XOR
//     -> pay_field 0 for '1','2' and 1 for '3','4'; frame_done.
//  3. "$GPGGA,..." -> comparer rejects at 'G' (byte 4) -> frame_skip; state IDLE; cmp_restart=1.
//  4. "$GPZDA,1*54" -> frame_error; "$GPZDA,1*5g" -> frame_error at the 'g' byte.
//  5. "$GPZDA,12" then TIMEOUT silent cycles -> frame_error exactly at TIMEOUT.
//     Repeat with "$GPZ" stalled -> no pulse, IDLE.
//  6. "$GPZDA,1$GPZDA,1*55" -> frame_error at the 2nd '$', then frame_done.
//     Reset asserted mid-payload -> all outputs 0 and cmp_restart=1 next cycle.

Source files
------------

// File: rtl/zda_frame_sequencer.sv
`timescale 1ns/1ps
// NMEA ZDA frame sequencer: hunts '$', drives an external header comparer,
// forwards comma-indexed payload bytes and verifies the trailing XOR checksum.
module zda_frame_sequencer #(
    parameter int unsigned B       = 8,
    parameter int unsigned L       = 6,
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned MAX_LEN = 82,
    parameter int unsigned FW      = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [B-1:0]  rx_data,
    output logic          cmp_restart,
    output logic          cmp_load,
    output logic [B-1:0]  cmp_data,
    input  logic          cmp_resolve,
    input  logic          cmp_reject,
    output logic          frame_start,
    output logic          pay_valid,
    output logic [B-1:0]  pay_data,
    output logic [FW-1:0] pay_field,
    output logic          frame_done,
    output logic          frame_error,
    output logic          frame_skip
);
    localparam int unsigned HW = $clog2(L + 1);
    localparam int unsigned PW = $clog2(MAX_LEN + 2);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [B-1:0] CH_DOLLAR = B'(8'h24);
    localparam logic [B-1:0] CH_COMMA  = B'(8'h2C);
    localparam logic [B-1:0] CH_STAR   = B'(8'h2A);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_CKSUM_HI,
        S_CKSUM_LO
    } state_t;

    state_t        state_q, state_d, eff_s;
    logic [HW-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [PW-1:0] pay_cnt_q, pay_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    vwait_q, vwait_d;
    logic          pend_q, pend_d;
    logic [B-1:0]  xacc_q, xacc_d;
    logic [FW-1:0] field_q, field_d;
    logic [3:0]    hi_q, hi_d;

    logic          cmp_restart_q, cmp_restart_d;
    logic          cmp_load_q, cmp_load_d;
    logic [B-1:0]  cmp_data_q, cmp_data_d;
    logic          frame_start_q, frame_start_d;
    logic          pay_valid_q, pay_valid_d;
    logic [B-1:0]  pay_data_q, pay_data_d;
    logic [FW-1:0] pay_field_q, pay_field_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_error_q, frame_error_d;
    logic          frame_skip_q, frame_skip_d;

    logic [4:0]    hex_c;
    logic          tmr_hit;
    logic          hdr_full;
    logic          over_len;

    // {valid, nibble} for uppercase hex digits only
    function automatic logic [4:0] hex_nibble(input logic [B-1:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= B'(8'h30) && c <= B'(8'h39)) begin
            r = {1'b1, 4'(c - B'(8'h30))};
        end else if (c >= B'(8'h41) && c <= B'(8'h46)) begin
            r = {1'b1, 4'(c - B'(8'h37))};
        end
        return r;
    endfunction

    assign hex_c    = hex_nibble(rx_data);
    assign tmr_hit  = (tmr_q == TW'(TIMEOUT - 1));
    assign hdr_full = (hdr_cnt_q == HW'(L));
    assign over_len = (pay_cnt_q >= PW'(MAX_LEN));

    // Next-state: comparer verdict first, then the received byte, then timers
    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        pay_cnt_d     = pay_cnt_q;
        tmr_d         = tmr_q;
        vwait_d       = vwait_q;
        pend_d        = 1'b0;
        xacc_d        = xacc_q;
        field_d       = field_q;
        hi_d          = hi_q;
        cmp_load_d    = 1'b0;
        cmp_data_d    = cmp_data_q;
        frame_start_d = 1'b0;
        pay_valid_d   = 1'b0;
        pay_data_d    = pay_data_q;
        pay_field_d   = pay_field_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        frame_skip_d  = 1'b0;
        eff_s         = state_q;

        if (state_q == S_IDLE) begin
            if (pend_q || (rx_valid && rx_data == CH_DOLLAR)) begin
                state_d    = S_HEADER;
                cmp_load_d = 1'b1;
                cmp_data_d = CH_DOLLAR;
                hdr_cnt_d  = HW'(1);
                pay_cnt_d  = '0;
                tmr_d      = '0;
                vwait_d    = '0;
                xacc_d     = '0;
                field_d    = '0;
            end
        end else begin
            if (state_q == S_HEADER) begin
                if (cmp_reject) begin
                    state_d      = S_IDLE;
                    frame_skip_d = 1'b1;
                    eff_s        = S_IDLE;
                end else if (cmp_resolve) begin
                    state_d       = S_PAYLOAD;
                    frame_start_d = 1'b1;
                    field_d       = '0;
                    eff_s         = S_PAYLOAD;
                end else if (hdr_full && vwait_q != 2'd2) begin
                    vwait_d = vwait_q + 2'd1;
                end
            end

            if (rx_valid) begin
                tmr_d = '0;
                if (rx_data == CH_DOLLAR) begin
                    // resync: one restart cycle in IDLE, then reload '$'
                    state_d = S_IDLE;
                    pend_d  = 1'b1;
                    if (eff_s inside {S_PAYLOAD, S_CKSUM_HI, S_CKSUM_LO}) begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    case (eff_s)
                        S_HEADER: begin
                            xacc_d = xacc_q ^ rx_data;
                            if (!hdr_full) begin
                                cmp_load_d = 1'b1;
                                cmp_data_d = rx_data;
                                hdr_cnt_d  = hdr_cnt_q + HW'(1);
                                vwait_d    = '0;
                            end else begin
                                pay_cnt_d = pay_cnt_q + PW'(1);
                            end
                        end
                        S_PAYLOAD: begin
                            if (over_len) begin
                                state_d       = S_IDLE;
                                frame_error_d = 1'b1;
                            end else begin
                                pay_cnt_d = pay_cnt_q + PW'(1);
                                if (pay_cnt_q == '0) begin
                                    xacc_d = xacc_q ^ rx_data;
                                end else if (rx_data == CH_COMMA) begin
                                    xacc_d = xacc_q ^ rx_data;
                                    if (field_q != {FW{1'b1}}) begin
                                        field_d = field_q + FW'(1);
                                    end
                                end else if (rx_data == CH_STAR) begin
                                    state_d = S_CKSUM_HI;
                                end else begin
                                    xacc_d      = xacc_q ^ rx_data;
                                    pay_valid_d = 1'b1;
                                    pay_data_d  = rx_data;
                                    pay_field_d = field_q;
                                end
                            end
                        end
                        S_CKSUM_HI: begin
                            if (over_len || !hex_c[4]) begin
                                state_d       = S_IDLE;
                                frame_error_d = 1'b1;
                            end else begin
                                pay_cnt_d = pay_cnt_q + PW'(1);
                                hi_d      = hex_c[3:0];
                                state_d   = S_CKSUM_LO;
                            end
                        end
                        S_CKSUM_LO: begin
                            state_d = S_IDLE;
                            if (!over_len && hex_c[4] && xacc_q == B'({hi_q, hex_c[3:0]})) begin
                                frame_done_d = 1'b1;
                            end else begin
                                frame_error_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (eff_s)
                    S_HEADER: begin
                        if (hdr_full && vwait_q == 2'd2) begin
                            state_d       = S_IDLE;
                            frame_error_d = 1'b1;
                        end else if (tmr_hit) begin
                            state_d = S_IDLE;
                        end else begin
                            tmr_d = tmr_q + TW'(1);
                        end
                    end
                    S_PAYLOAD, S_CKSUM_HI, S_CKSUM_LO: begin
                        if (tmr_hit) begin
                            state_d       = S_IDLE;
                            frame_error_d = 1'b1;
                        end else begin
                            tmr_d = tmr_q + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        // frame status pulses stay mutually exclusive
        if (frame_error_d) begin
            frame_start_d = 1'b0;
        end
        cmp_restart_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            hdr_cnt_q     <= '0;
            pay_cnt_q     <= '0;
            tmr_q         <= '0;
            vwait_q       <= '0;
            pend_q        <= 1'b0;
            xacc_q        <= '0;
            field_q       <= '0;
            hi_q          <= '0;
            cmp_restart_q <= 1'b1;
            cmp_load_q    <= 1'b0;
            cmp_data_q    <= '0;
            frame_start_q <= 1'b0;
            pay_valid_q   <= 1'b0;
            pay_data_q    <= '0;
            pay_field_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            frame_skip_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            pay_cnt_q     <= pay_cnt_d;
            tmr_q         <= tmr_d;
            vwait_q       <= vwait_d;
            pend_q        <= pend_d;
            xacc_q        <= xacc_d;
            field_q       <= field_d;
            hi_q          <= hi_d;
            cmp_restart_q <= cmp_restart_d;
            cmp_load_q    <= cmp_load_d;
            cmp_data_q    <= cmp_data_d;
            frame_start_q <= frame_start_d;
            pay_valid_q   <= pay_valid_d;
            pay_data_q    <= pay_data_d;
            pay_field_q   <= pay_field_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            frame_skip_q  <= frame_skip_d;
        end
    end

    assign cmp_restart = cmp_restart_q;
    assign cmp_load    = cmp_load_q;
    assign cmp_data    = cmp_data_q;
    assign frame_start = frame_start_q;
    assign pay_valid   = pay_valid_q;
    assign pay_data    = pay_data_q;
    assign pay_field   = pay_field_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign frame_skip  = frame_skip_q;

endmodule

// File: tb/tb_zda_frame_sequencer.sv
`timescale 1ns/1ps
// Directed bench for zda_frame_sequencer with a behavioural "$GPZDA" header comparer.
module tb_zda_frame_sequencer;
    localparam int unsigned B       = 8;
    localparam int unsigned L       = 6;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned MAX_LEN = 24;
    localparam int unsigned FW      = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [B-1:0]  rx_data;
    logic          cmp_restart, cmp_load;
    logic [B-1:0]  cmp_data;
    logic          cmp_resolve, cmp_reject;
    logic          frame_start, pay_valid, frame_done, frame_error, frame_skip;
    logic [B-1:0]  pay_data;
    logic [FW-1:0] pay_field;

    always #5 clk = ~clk;

    zda_frame_sequencer #(.B(B), .L(L), .TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN), .FW(FW)) dut (
        .clock(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .cmp_restart(cmp_restart), .cmp_load(cmp_load), .cmp_data(cmp_data),
        .cmp_resolve(cmp_resolve), .cmp_reject(cmp_reject),
        .frame_start(frame_start), .pay_valid(pay_valid), .pay_data(pay_data),
        .pay_field(pay_field), .frame_done(frame_done), .frame_error(frame_error),
        .frame_skip(frame_skip)
    );

    // Comparer model: expects "$GPZDA", answers one cycle after each load
    logic [2:0] cm_idx;
    logic       cm_dead;
    logic       cm_mute;

    function automatic logic [7:0] hdr_char(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h24;
            3'd1:    return 8'h47;
            3'd2:    return 8'h50;
            3'd3:    return 8'h5A;
            3'd4:    return 8'h44;
            3'd5:    return 8'h41;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cmp_resolve <= 1'b0;
            cmp_reject  <= 1'b0;
            cm_idx      <= 3'd0;
            cm_dead     <= 1'b0;
        end else begin
            cmp_resolve <= 1'b0;
            cmp_reject  <= 1'b0;
            if (cmp_restart) begin
                cm_idx  <= 3'd0;
                cm_dead <= 1'b0;
            end else if (cmp_load && !cm_dead && !cm_mute) begin
                cm_idx <= cm_idx + 3'd1;
                if (cmp_data != hdr_char(cm_idx)) begin
                    cmp_reject <= 1'b1;
                    cm_dead    <= 1'b1;
                end else if (cm_idx == 3'd5) begin
                    cmp_resolve <= 1'b1;
                    cm_dead     <= 1'b1;
                end
            end
        end
    end

    // Event monitor sampled on the falling edge
    int         n_start = 0, n_done = 0, n_err = 0, n_skip = 0;
    logic [7:0] pay_n = 8'd0;
    logic [7:0] pay_d_log [256];
    logic [3:0] pay_f_log [256];

    always @(negedge clk) begin
        if (frame_start) n_start <= n_start + 1;
        if (frame_done)  n_done  <= n_done + 1;
        if (frame_error) n_err   <= n_err + 1;
        if (frame_skip)  n_skip  <= n_skip + 1;
        if (pay_valid) begin
            pay_d_log[pay_n] <= pay_data;
            pay_f_log[pay_n] <= pay_field;
            pay_n            <= pay_n + 8'd1;
        end
    end

    int         n_cmp = 0, n_bad = 0;
    int         b_start, b_done, b_err, b_skip;
    logic [7:0] b_pay;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_start = n_start; b_done = n_done; b_err = n_err; b_skip = n_skip; b_pay = pay_n;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one strobe; returns at the falling edge where its registered effect is visible
    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            put(8'(s.getc(i)));
            gap(3);
        end
    endtask

    task automatic chk_counts(input string tag, input int s, input int d, input int e, input int k, input int p);
        chk({tag, "_start"}, 32'(n_start - b_start), 32'(s));
        chk({tag, "_done"},  32'(n_done - b_done),   32'(d));
        chk({tag, "_err"},   32'(n_err - b_err),     32'(e));
        chk({tag, "_skip"},  32'(n_skip - b_skip),   32'(k));
        chk({tag, "_npay"},  32'(pay_n - b_pay),     32'(p));
    endtask

    task automatic chk_pay(input string tag, input int k, input logic [7:0] d, input logic [3:0] f);
        chk({tag, "_data"},  32'(pay_d_log[b_pay + 8'(k)]), 32'(d));
        chk({tag, "_field"}, 32'(pay_f_log[b_pay + 8'(k)]), 32'(f));
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; cm_mute = 1'b0;
        gap(3);
        chk("rst_ctl", 32'({cmp_restart, cmp_load, frame_start, pay_valid, frame_done, frame_error, frame_skip}), 32'(7'b1000000));
        chk("rst_data", 32'({cmp_data, pay_data, pay_field}), 32'(0));
        reset = 1'b0;
        gap(2);

        // 1: minimal valid sentence
        snap();
        put(8'h24);
        chk("t1_first_load", 32'({cmp_restart, cmp_load, cmp_data}), 32'({1'b0, 1'b1, 8'h24}));
        gap(3);
        send("GPZDA,1*55");
        chk_counts("t1", 1, 1, 0, 0, 1);
        chk_pay("t1_p0", 0, 8'h31, 4'd0);
        chk("t1_idle_restart", 32'(cmp_restart), 32'(1));

        // 2: two fields, checksum 0x4C
        snap();
        send("$GPZDA,12,34*4C");
        chk_counts("t2", 1, 1, 0, 0, 4);
        chk_pay("t2_p0", 0, 8'h31, 4'd0);
        chk_pay("t2_p1", 1, 8'h32, 4'd0);
        chk_pay("t2_p2", 2, 8'h33, 4'd1);
        chk_pay("t2_p3", 3, 8'h34, 4'd1);

        // 3: other sentence type rejected at byte 4, rest ignored
        snap();
        send("$GPG");
        chk_counts("t3a", 0, 0, 0, 1, 0);
        chk("t3_restart", 32'(cmp_restart), 32'(1));
        send("GA,1*00");
        chk_counts("t3b", 0, 0, 0, 1, 0);

        // 4: bad checksum value, then non-hex checksum digit
        snap();
        send("$GPZDA,1*54");
        chk_counts("t4a", 1, 0, 1, 0, 1);
        snap();
        send("$GPZDA,1*5");
        put(8'h67);
        chk("t4b_err_at_g", 32'(frame_error), 32'(1));
        gap(3);
        chk_counts("t4b", 1, 0, 1, 0, 1);

        // 5: payload timeout lands exactly TIMEOUT silent cycles after the last byte
        snap();
        send("$GPZDA,1");
        put(8'h32);
        gap(TIMEOUT - 1);
        chk("t5_no_err_early", 32'(frame_error), 32'(0));
        gap(1);
        chk("t5_err_on_time", 32'(frame_error), 32'(1));
        gap(2);
        chk_counts("t5a", 1, 0, 1, 0, 2);
        chk("t5a_restart", 32'(cmp_restart), 32'(1));
        snap();
        send("$GPZ");
        gap(TIMEOUT + 5);
        chk_counts("t5b", 0, 0, 0, 0, 0);
        chk("t5b_restart", 32'(cmp_restart), 32'(1));

        // comparer that never answers after a full header
        cm_mute = 1'b1;
        snap();
        send("$GPZD");
        put(8'h41);
        gap(2);
        chk("tv_no_err_early", 32'(frame_error), 32'(0));
        gap(1);
        chk("tv_err", 32'(frame_error), 32'(1));
        cm_mute = 1'b0;
        gap(3);
        chk_counts("tv", 0, 0, 1, 0, 0);

        // 6: resync inside payload
        snap();
        send("$GPZDA,1");
        put(8'h24);
        chk("t6_resync", 32'({frame_error, cmp_restart, cmp_load}), 32'(3'b110));
        gap(1);
        chk("t6_reload", 32'({cmp_restart, cmp_load, cmp_data}), 32'({1'b0, 1'b1, 8'h24}));
        gap(2);
        send("GPZDA,1*55");
        chk_counts("t6", 2, 1, 1, 0, 2);

        // overlength: MAX_LEN bytes after header allowed, the next one aborts
        snap();
        send("$GPZDA,");
        for (int i = 0; i < int'(MAX_LEN) - 1; i++) send("x");
        chk("tl_no_err", 32'(n_err - b_err), 32'(0));
        put(8'h78);
        chk("tl_err_now", 32'(frame_error), 32'(1));
        gap(3);
        chk_counts("tl", 1, 0, 1, 0, int'(MAX_LEN) - 1);

        // field index saturates at 2^FW-1
        snap();
        send("$GPZDA,");
        for (int i = 0; i < 16; i++) send(",");
        send("x*1C");
        chk_counts("ts", 1, 1, 0, 0, 1);
        chk_pay("ts_p0", 0, 8'h78, 4'd15);

        // reset mid-payload
        send("$GPZDA,1");
        rx_valid = 1'b1; rx_data = 8'h32; reset = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("tr_ctl", 32'({cmp_restart, cmp_load, frame_start, pay_valid, frame_done, frame_error, frame_skip}), 32'(7'b1000000));
        chk("tr_data", 32'({cmp_data, pay_data, pay_field}), 32'(0));
        reset = 1'b0;
        gap(2);
        snap();
        send("GPZDA,1*55");
        chk_counts("tr", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
